// File: rtl/muldiv_sequencer.sv
// Iterative signed mul/div/mod unit that stalls the core while a shift-add or restoring loop runs.
// Optional MULDIV_EARLY_OUT_EN: trivial operands (op2==0, op2==1, op1==0) skip the loop.
module muldiv_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            isMul,
  input  logic            isDiv,
  input  logic            isMod,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_MOD} op_t;

  state_t           r_state;
  op_t              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic [XLEN-1:0]  r_result;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_rem;

  op_t              w_op;
  logic             w_accept;
  logic             w_neg;
  logic [XLEN-1:0]  w_abs1;
  logic [XLEN-1:0]  w_abs2;
  logic [XLEN:0]    w_rem_sh;
  logic             w_ge;
  logic [XLEN-1:0]  w_acc_nx;
  logic [XLEN-1:0]  w_a_nx;
  logic [XLEN-1:0]  w_b_nx;
  logic [XLEN-1:0]  w_rem_nx;
  logic [XLEN-1:0]  w_mag;
  logic [XLEN-1:0]  w_final;

  always_comb begin
    w_op = OP_MOD;
    if (isMul)      w_op = OP_MUL;
    else if (isDiv) w_op = OP_DIV;
  end

  assign w_accept = (r_state == S_IDLE) && start && (isMul || isDiv || isMod);
  assign w_abs1   = op1[XLEN-1] ? -op1 : op1;
  assign w_abs2   = op2[XLEN-1] ? -op2 : op2;
  assign w_neg    = (w_op == OP_MOD) ? op1[XLEN-1] : (op1[XLEN-1] ^ op2[XLEN-1]);

  // Magnitudes are unsigned XLEN bits (|INT_MIN| fits); the partial remainder
  // carries one extra bit so the trial subtraction never overflows.
  always_comb begin
    w_rem_sh = {r_rem, r_a[XLEN-1]};
    w_ge     = w_rem_sh >= {1'b0, r_b};
    w_acc_nx = r_acc;
    w_a_nx   = r_a;
    w_b_nx   = r_b;
    w_rem_nx = r_rem;
    if (r_op == OP_MUL) begin
      w_acc_nx = r_b[0] ? (r_acc + r_a) : r_acc;
      w_a_nx   = r_a << 1;
      w_b_nx   = r_b >> 1;
    end else begin
      w_rem_nx = w_ge ? XLEN'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[XLEN-1:0];
      w_a_nx   = {r_a[XLEN-2:0], w_ge};
    end
  end

  always_comb begin
    w_mag = w_rem_nx;
    if (r_op == OP_MUL)      w_mag = w_acc_nx;
    else if (r_op == OP_DIV) w_mag = w_a_nx;
    w_final = r_neg ? -w_mag : w_mag;
    if ((r_op == OP_DIV) && r_dz) w_final = '1;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            w_early;
  logic [XLEN-1:0] w_early_res;

  assign w_early = (op2 == '0) || (op2 == XLEN'(1)) || (op1 == '0);

  always_comb begin
    w_early_res = '0;
    case (w_op)
      OP_MUL: w_early_res = ((op1 == '0) || (op2 == '0)) ? '0 : op1;
      OP_DIV: w_early_res = (op2 == '0) ? '1 : ((op2 == XLEN'(1)) ? op1 : '0);
      default: w_early_res = (op2 == '0) ? op1 : '0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= w_op;
            r_neg <= w_neg;
            r_dz  <= (op2 == '0);
            r_cnt <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_a   <= w_abs1;
            r_b   <= w_abs2;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_early) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_early_res;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
`else
            r_state <= S_CALC;
            r_busy  <= 1'b1;
`endif
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nx;
          r_a   <= w_a_nx;
          r_b   <= w_b_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(XLEN - 1)) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_final;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall is raised in the accepting cycle itself; gating with reset drops it asynchronously.
  assign stall  = reset && (w_accept || (r_state == S_CALC));
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
